// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: 640x480@60 defaults,
// sync polarity names and a helper that sums an axis into its total length.
package vga_timing_pkg;

   localparam int SYNC_NEG = 0;
   localparam int SYNC_POS = 1;

   localparam int DEF_H_VIS  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_VIS  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;
   localparam int DEF_H_TAP  = 264;

   function automatic int totalOf(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One timing axis: a wrapping position counter plus registered sync/visible/wrap
// flags decoded from the next count, so every flag lines up with cnt.
module vga_timing_axis
   import vga_timing_pkg::*;
#(
   parameter int VIS  = DEF_H_VIS,
   parameter int FP   = DEF_H_FP,
   parameter int SYNC = DEF_H_SYNC,
   parameter int BP   = DEF_H_BP,
   parameter int POL  = SYNC_NEG,
   parameter int W    = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         adv,
   output logic [W-1:0] cnt,
   output logic         sync,
   output logic         vis,
   output logic         wrap
);

   localparam int TOTAL = totalOf(VIS, FP, SYNC, BP);

   // BP >= 1 guarantees the sync end boundary still fits in W bits
   if (FP < 1 || SYNC < 1 || BP < 1 || TOTAL > (1 << W)) begin : g_badParams
      $fatal(1, "vga_timing_axis: zero porch/sync width or W too small for total");
   end

   localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
   localparam logic [W-1:0] SYNC_LO = W'(VIS + FP);
   localparam logic [W-1:0] SYNC_HI = W'(VIS + FP + SYNC);
   localparam logic [W-1:0] VIS_END = W'(VIS);
   localparam logic         SYNC_ON = (POL != 0);

   logic [W-1:0] r_cnt;
   logic         r_sync;
   logic         r_vis;
   logic         r_wrap;
   logic [W-1:0] w_next;

   always_comb begin
      w_next = (r_cnt == LAST) ? '0 : r_cnt + W'(1);
   end

   // Reset parks the axis on its last position, inside the back porch
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= LAST;
         r_sync <= ~SYNC_ON;
         r_vis  <= 1'b0;
         r_wrap <= 1'b1;
      end else if (adv) begin
         r_cnt  <= w_next;
         r_sync <= (w_next >= SYNC_LO && w_next < SYNC_HI) ? SYNC_ON : ~SYNC_ON;
         r_vis  <= (w_next < VIS_END);
         r_wrap <= (w_next == LAST);
      end
   end

   assign cnt  = r_cnt;
   assign sync = r_sync;
   assign vis  = r_vis;
   assign wrap = r_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Horizontal + vertical video timing generator with pixel enable, coordinates,
// a programmable horizontal tap pulse and line/frame markers.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VIS  = DEF_H_VIS,
   parameter int H_FP   = DEF_H_FP,
   parameter int H_SYNC = DEF_H_SYNC,
   parameter int H_BP   = DEF_H_BP,
   parameter int V_VIS  = DEF_V_VIS,
   parameter int V_FP   = DEF_V_FP,
   parameter int V_SYNC = DEF_V_SYNC,
   parameter int V_BP   = DEF_V_BP,
   parameter int HS_POL = SYNC_NEG,
   parameter int VS_POL = SYNC_NEG,
   parameter int H_TAP  = DEF_H_TAP,
   parameter int X_W    = 10,
   parameter int Y_W    = 10
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           pix_en,
   output logic           hsync,
   output logic           vsync,
   output logic           hblank_n,
   output logic           vblank_n,
   output logic           de,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           h_tap,
   output logic           line_end,
   output logic           frame_start
);

   localparam int H_TOTAL = totalOf(H_VIS, H_FP, H_SYNC, H_BP);

   // An out-of-range tap is disabled outright rather than aliased by truncation
   localparam logic           TAP_EN       = (H_TAP >= 0 && H_TAP < H_TOTAL);
   localparam logic [X_W-1:0] TAP_VAL      = TAP_EN ? X_W'(H_TAP) : '0;
   localparam logic           TAP_AT_RESET = TAP_EN && (H_TAP == H_TOTAL - 1);
   localparam logic [X_W-1:0] H_VIS_END    = X_W'(H_VIS);
   localparam logic [Y_W-1:0] V_VIS_END    = Y_W'(V_VIS);

   logic [X_W-1:0] w_hCnt;
   logic [Y_W-1:0] w_vCnt;
   logic           w_hWrap;
   logic           w_vWrap;
   logic           w_hVis;
   logic           w_vVis;
   logic           w_vAdv;
   logic [X_W-1:0] w_hNext;
   logic [Y_W-1:0] w_vNext;

   logic           r_hTap;
   logic           r_frameStart;
   logic           r_de;

   assign w_vAdv = pix_en & w_hWrap;

   vga_timing_axis #(
      .VIS (H_VIS), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (HS_POL), .W (X_W)
   ) u_hAxis (
      .clk (clk), .reset_n (reset_n), .adv (pix_en),
      .cnt (w_hCnt), .sync (hsync), .vis (w_hVis), .wrap (w_hWrap)
   );

   vga_timing_axis #(
      .VIS (V_VIS), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (VS_POL), .W (Y_W)
   ) u_vAxis (
      .clk (clk), .reset_n (reset_n), .adv (w_vAdv),
      .cnt (w_vCnt), .sync (vsync), .vis (w_vVis), .wrap (w_vWrap)
   );

   // Mirror of the axes' next positions, used to register the top-level decodes
   always_comb begin
      w_hNext = w_hWrap ? '0 : w_hCnt + X_W'(1);
      w_vNext = w_vCnt;
      if (w_hWrap) begin
         w_vNext = w_vWrap ? '0 : w_vCnt + Y_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hTap       <= TAP_AT_RESET;
         r_frameStart <= 1'b0;
         r_de         <= 1'b0;
      end else if (pix_en) begin
         r_hTap       <= TAP_EN && (w_hNext == TAP_VAL);
         r_frameStart <= (w_hNext == '0) && (w_vNext == '0);
         r_de         <= (w_hNext < H_VIS_END) && (w_vNext < V_VIS_END);
      end
   end

   assign hblank_n    = w_hVis;
   assign vblank_n    = w_vVis;
   assign de          = r_de;
   assign x           = w_hCnt;
   assign y           = w_vCnt;
   assign h_tap       = r_hTap;
   assign line_end    = w_hWrap;
   assign frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Drives three vga_timing_gen instances (default 640x480, and two tiny frames with
// opposite polarities and edge-case taps) from one randomized pix_en stream.
module tb_vga_timing_gen;

   // Instance 0 = defaults, 1 = positive polarity + unreachable tap, 2 = tap on last pixel
   localparam int P_HV  [3] = '{640, 8, 6};
   localparam int P_HF  [3] = '{16, 2, 1};
   localparam int P_HS  [3] = '{96, 3, 2};
   localparam int P_HB  [3] = '{48, 2, 3};
   localparam int P_VV  [3] = '{480, 4, 3};
   localparam int P_VF  [3] = '{10, 1, 2};
   localparam int P_VS  [3] = '{2, 2, 1};
   localparam int P_VB  [3] = '{33, 1, 2};
   localparam int P_HP  [3] = '{0, 1, 0};
   localparam int P_VP  [3] = '{0, 1, 0};
   localparam int P_TAP [3] = '{264, 20, 11};

   logic clk = 1'b0;
   logic resetN;
   logic pixEn;

   logic hsyncA, vsyncA, hbA, vbA, deA, tapA, leA, fsA;
   logic hsyncB, vsyncB, hbB, vbB, deB, tapB, leB, fsB;
   logic hsyncC, vsyncC, hbC, vbC, deC, tapC, leC, fsC;
   logic [9:0] xA, yA;
   logic [3:0] xB, xC;
   logic [2:0] yB, yC;

   logic [7:0]  obsFlags [3];
   logic [31:0] obsX [3];
   logic [31:0] obsY [3];

   int mx [3];
   int my [3];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   vga_timing_gen dutA (
      .clk (clk), .reset_n (resetN), .pix_en (pixEn),
      .hsync (hsyncA), .vsync (vsyncA), .hblank_n (hbA), .vblank_n (vbA), .de (deA),
      .x (xA), .y (yA), .h_tap (tapA), .line_end (leA), .frame_start (fsA)
   );

   vga_timing_gen #(
      .H_VIS (P_HV[1]), .H_FP (P_HF[1]), .H_SYNC (P_HS[1]), .H_BP (P_HB[1]),
      .V_VIS (P_VV[1]), .V_FP (P_VF[1]), .V_SYNC (P_VS[1]), .V_BP (P_VB[1]),
      .HS_POL (P_HP[1]), .VS_POL (P_VP[1]), .H_TAP (P_TAP[1]), .X_W (4), .Y_W (3)
   ) dutB (
      .clk (clk), .reset_n (resetN), .pix_en (pixEn),
      .hsync (hsyncB), .vsync (vsyncB), .hblank_n (hbB), .vblank_n (vbB), .de (deB),
      .x (xB), .y (yB), .h_tap (tapB), .line_end (leB), .frame_start (fsB)
   );

   vga_timing_gen #(
      .H_VIS (P_HV[2]), .H_FP (P_HF[2]), .H_SYNC (P_HS[2]), .H_BP (P_HB[2]),
      .V_VIS (P_VV[2]), .V_FP (P_VF[2]), .V_SYNC (P_VS[2]), .V_BP (P_VB[2]),
      .HS_POL (P_HP[2]), .VS_POL (P_VP[2]), .H_TAP (P_TAP[2]), .X_W (4), .Y_W (3)
   ) dutC (
      .clk (clk), .reset_n (resetN), .pix_en (pixEn),
      .hsync (hsyncC), .vsync (vsyncC), .hblank_n (hbC), .vblank_n (vbC), .de (deC),
      .x (xC), .y (yC), .h_tap (tapC), .line_end (leC), .frame_start (fsC)
   );

   assign obsFlags[0] = {hsyncA, vsyncA, hbA, vbA, deA, tapA, leA, fsA};
   assign obsFlags[1] = {hsyncB, vsyncB, hbB, vbB, deB, tapB, leB, fsB};
   assign obsFlags[2] = {hsyncC, vsyncC, hbC, vbC, deC, tapC, leC, fsC};
   assign obsX[0] = 32'(xA);
   assign obsX[1] = 32'(xB);
   assign obsX[2] = 32'(xC);
   assign obsY[0] = 32'(yA);
   assign obsY[1] = 32'(yB);
   assign obsY[2] = 32'(yC);

   function automatic int hTotal(input int k);
      return P_HV[k] + P_HF[k] + P_HS[k] + P_HB[k];
   endfunction

   function automatic int vTotal(input int k);
      return P_VV[k] + P_VF[k] + P_VS[k] + P_VB[k];
   endfunction

   // Expected flags straight from the region rules at the model position
   function automatic logic [7:0] expFlags(input int k);
      int  h = mx[k];
      int  v = my[k];
      bit  hsAct = (h >= P_HV[k] + P_HF[k]) && (h < P_HV[k] + P_HF[k] + P_HS[k]);
      bit  vsAct = (v >= P_VV[k] + P_VF[k]) && (v < P_VV[k] + P_VF[k] + P_VS[k]);
      bit  hsLvl = hsAct ? (P_HP[k] != 0) : (P_HP[k] == 0);
      bit  vsLvl = vsAct ? (P_VP[k] != 0) : (P_VP[k] == 0);
      bit  hVis  = (h < P_HV[k]);
      bit  vVis  = (v < P_VV[k]);
      return {hsLvl, vsLvl, hVis, vVis, hVis && vVis, h == P_TAP[k],
              h == hTotal(k) - 1, (h == 0) && (v == 0)};
   endfunction

   task automatic setModelsReset();
      for (int k = 0; k < 3; k++) begin
         mx[k] = hTotal(k) - 1;
         my[k] = vTotal(k) - 1;
      end
   endtask

   task automatic advanceModels();
      for (int k = 0; k < 3; k++) begin
         mx[k] = (mx[k] + 1) % hTotal(k);
         if (mx[k] == 0) my[k] = (my[k] + 1) % vTotal(k);
      end
   endtask

   task automatic checkOutput(input string tag);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         assert (obsFlags[k] === expFlags(k)) else begin
            miscompares++;
            $error("[TB] FAIL %s dut%0d flags{hs,vs,hb,vb,de,tap,le,fs} got %b want %b at model (%0d,%0d)",
                   tag, k, obsFlags[k], expFlags(k), mx[k], my[k]);
         end
         vectors++;
         assert (obsX[k] === mx[k]) else begin
            miscompares++;
            $error("[TB] FAIL %s dut%0d x got %0d want %0d", tag, k, obsX[k], mx[k]);
         end
         vectors++;
         assert (obsY[k] === my[k]) else begin
            miscompares++;
            $error("[TB] FAIL %s dut%0d y got %0d want %0d", tag, k, obsY[k], my[k]);
         end
      end
   endtask

   // Called at a negedge: drive pix_en, let one rising edge happen, check at the next negedge
   task automatic applyStimulus(input logic en, input string tag);
      pixEn = en;
      @(posedge clk);
      if (en) advanceModels();
      @(negedge clk);
      checkOutput(tag);
   endtask

   initial begin
      resetN = 1'b0;
      pixEn  = 1'b0;
      setModelsReset();
      #12;
      checkOutput("reset");

      @(negedge clk);
      resetN = 1'b1;
      applyStimulus(1'b1, "firstPixel");
      vectors++;
      assert (xA === 10'd0 && yA === 10'd0 && fsA === 1'b1 && deA === 1'b1) else begin
         miscompares++;
         $error("[TB] FAIL firstPixelDirect got x=%0d y=%0d fs=%b de=%b want 0 0 1 1", xA, yA, fsA, deA);
      end

      for (int i = 0; i < 1000; i++) applyStimulus(1'b1, "freeRun");

      for (int i = 0; i < 300; i++) applyStimulus((i % 3) == 0, "enEveryThird");

      for (int i = 0; i < 1500; i++) applyStimulus(1'($urandom_range(0, 1)), "randomEn");

      for (int i = 0; i < 1000 && mx[0] != 700; i++) applyStimulus(1'b1, "seekMidSync");
      vectors++;
      assert (obsX[0] === 32'd700 && hsyncA === 1'b0) else begin
         miscompares++;
         $error("[TB] FAIL midSyncPosition got x=%0d hsync=%b want 700 0", obsX[0], hsyncA);
      end

      #2;
      resetN = 1'b0;
      #1;
      setModelsReset();
      checkOutput("asyncReset");
      vectors++;
      assert (hsyncA === 1'b1 && deA === 1'b0 && xA === 10'd799 && yA === 10'd524) else begin
         miscompares++;
         $error("[TB] FAIL asyncResetDirect got hs=%b de=%b x=%0d y=%0d want 1 0 799 524",
                hsyncA, deA, xA, yA);
      end

      @(negedge clk);
      checkOutput("heldInReset");
      resetN = 1'b1;
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, "afterRelease");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
